// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: merges load-use, branch flush and
// data-memory wait handling into register load enables, a flush and a bubble select.
module pipeline_stall_controller #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             load_use_hz,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             PC_ld,
    output logic             IF_ID_ld,
    output logic             ID_EX_ld,
    output logic             EX_MEM_ld,
    output logic             MEM_WB_ld,
    output logic             IF_ID_clr,
    output logic             ID_EX_nop,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [1:0]       state,
    output logic [7:0]       wait_cnt
);

    // Handshake: mem_req qualifies a MEM-stage access; mem_ready=1 completes it in the
    // same cycle. With mem_req=1 and mem_ready=0 the whole pipeline holds until ready.

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b10,
        FAULT    = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};
    localparam logic [7:0]       TIMEOUT   = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] wait_q, wait_d;
    logic       fault_q, fault_d;
    logic       advance;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= RUN;
            wait_q       <= '0;
            fault_q      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_d;
            if (!PC_ld && stall_cycles != STALL_MAX)
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        fault_d   = fault_q;
        advance   = 1'b0;
        PC_ld     = 1'b0;
        IF_ID_ld  = 1'b0;
        ID_EX_ld  = 1'b0;
        EX_MEM_ld = 1'b0;
        MEM_WB_ld = 1'b0;
        IF_ID_clr = 1'b0;
        ID_EX_nop = 1'b0;

        case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    state_d = MEM_WAIT;
                    wait_d  = 8'd1;
                end else begin
                    advance = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    advance = 1'b1;
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_q == TIMEOUT) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase

        // Load-use outranks the branch flush: the held IF/ID re-resolves next cycle.
        if (advance && RSTn) begin
            ID_EX_ld  = 1'b1;
            EX_MEM_ld = 1'b1;
            MEM_WB_ld = 1'b1;
            if (load_use_hz) begin
                ID_EX_nop = 1'b1;
            end else begin
                PC_ld     = 1'b1;
                IF_ID_ld  = 1'b1;
                IF_ID_clr = branch_taken;
            end
        end
    end

    assign mem_fault = fault_q;
    assign state     = state_q;
    assign wait_cnt  = wait_q;

endmodule

// File: doc/pipeline_stall_controller.md
# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage ARM pipeline. Combines the hazard unit's load-use request, the ID-stage branch decision and the data-memory handshake into one set of pipeline-register load enables, an IF/ID flush and an ID/EX bubble select. A small FSM freezes the whole pipeline across multi-cycle data-memory accesses and traps a memory that never answers. Sits beside the hazard unit and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers and the control-unit NOP mux.

## Interface
- MEM_TIMEOUT, 15: wait cycles allowed in MEM_WAIT before FAULT; legal 1..255
- CNT_W, 16: width of the stall-cycle performance counter
- CLK  in  1  clock, all state on rising edge
- RSTn  in  1  reset, asynchronous, active-low
- load_use_hz  in  1  hazard unit load-use stall request (inverse of its HZld)
- branch_taken  in  1  ID-stage branch/condition resolved taken
- mem_req  in  1  instruction in MEM stage is a load or store
- mem_ready  in  1  data memory completes access this cycle
- PC_ld  out  1  PC load enable
- IF_ID_ld  out  1  IF/ID load enable
- ID_EX_ld  out  1  ID/EX load enable
- EX_MEM_ld  out  1  EX/MEM load enable
- MEM_WB_ld  out  1  MEM/WB load enable
- IF_ID_clr  out  1  flush IF/ID to NOP on next edge
- ID_EX_nop  out  1  select NOP control word into ID/EX (CU mux)
- mem_fault  out  1  sticky memory-timeout flag
- stall_cycles  out  CNT_W  saturating count of cycles with PC_ld=0

## Operation
- States: RUN (2'b00), MEM_WAIT (2'b10), FAULT (2'b11). Outputs are Mealy (state + current inputs); wait_cnt (8 bit), stall_cycles, mem_fault and state are registered.
- "Advance" decision, used in RUN and in MEM_WAIT when mem_ready=1, priority highest first:
  - load_use_hz=1: PC_ld=0, IF_ID_ld=0, ID_EX_nop=1, ID_EX_ld/EX_MEM_ld/MEM_WB_ld=1, IF_ID_clr=0. branch_taken is ignored this cycle (re-evaluated next cycle from the held IF/ID).
  - else branch_taken=1: all ld=1, IF_ID_clr=1, ID_EX_nop=0.
  - else: all ld=1, IF_ID_clr=0, ID_EX_nop=0.
- RUN:
  - mem_req=1 and mem_ready=0: freeze: all five ld=0, IF_ID_clr=0, ID_EX_nop=0; next MEM_WAIT; wait_cnt<=1.
  - otherwise apply advance decision; stay RUN.
- MEM_WAIT:
  - mem_ready=1: apply advance decision; next RUN; wait_cnt<=0.
  - mem_ready=0 and wait_cnt==MEM_TIMEOUT: freeze; next FAULT; mem_fault<=1.
  - mem_ready=0 otherwise: freeze; wait_cnt<=wait_cnt+1.
  - mem_req is not re-examined in MEM_WAIT.
- FAULT: all ld=0, IF_ID_clr=0, ID_EX_nop=0; mem_fault=1; exits only by reset.
- stall_cycles increments on every edge where PC_ld=0 (freeze, load-use, FAULT); holds at 2^CNT_W-1.

## Timing
- Reset (RSTn=0, asynchronous): state=RUN, wait_cnt=0, stall_cycles=0, mem_fault=0; while RSTn=0 all ld=0, IF_ID_clr=0, ID_EX_nop=0 regardless of inputs. First normal decision on the first edge after RSTn rises.
- Zero-latency control: enables/flush/bubble reflect same-cycle inputs; registers update on that edge.
- Single-cycle memory (mem_ready=1 with mem_req): no stall, no state change.
- Access with N wait cycles (mem_ready rises N cycles after entry, N<=MEM_TIMEOUT): exactly N frozen cycles, pipeline advances on cycle N+1.
- Timeout: mem_ready low for MEM_TIMEOUT+1 consecutive cycles from entry -> FAULT on that edge; mem_ready arriving in that same cycle wins (no fault).
- Load-use and pending memory stall together: freeze wins; load-use is re-applied in the releasing cycle if still asserted.
- Reset asserted in MEM_WAIT or FAULT: immediate return to RUN, counters cleared.

## Test plan
- Reset: hold RSTn=0 with all inputs 1 -> all ld=0, clr=0, nop=0, stall_cycles=0, mem_fault=0; release, idle inputs -> all ld=1 next cycle.
- Load-use: load_use_hz=1 for 1 cycle with branch_taken=1 -> PC_ld=IF_ID_ld=0, ID_EX_nop=1, IF_ID_clr=0; stall_cycles=1; next cycle branch_taken=1 alone -> IF_ID_clr=1.
- Memory wait: mem_req=1, mem_ready low 3 cycles then high -> 3 frozen cycles, state returns RUN, stall_cycles=3, mem_fault=0.
- Timeout boundary (MEM_TIMEOUT=4): ready arrives in 5th cycle -> no fault; repeat with ready never -> FAULT after 5 frozen cycles, mem_fault=1, outputs stay frozen.
- Reset mid-wait: RSTn low in MEM_WAIT cycle 2 -> outputs zero asynchronously, state RUN, wait_cnt=0 after release.
- Saturation (CNT_W=4): force FAULT 20 cycles -> stall_cycles stops at 15.
